// File: rtl/pacman_video_pkg.sv
// Shared frame-buffer geometry, palette and addressing helpers for the Pac-Man video path.
package pacman_video_pkg;

  localparam int unsigned FB_W       = 160;
  localparam int unsigned FB_H       = 120;
  localparam int unsigned CELL_SHIFT = 2;
  localparam int unsigned FB_CELLS   = FB_W * FB_H;
  localparam int unsigned FB_ADDR_W  = 15;

  typedef logic [3:0]           color_idx_t;
  typedef logic [FB_ADDR_W-1:0] fb_addr_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  function automatic rgb_t palette_lookup(color_idx_t idx);
    rgb_t c;
    case (idx)
      4'h0:    c = 24'h000000;
      4'h1:    c = 24'h2121DE;
      4'h2:    c = 24'hFFFF00;
      4'h3:    c = 24'hFF0000;
      4'h4:    c = 24'hFFB8FF;
      4'h5:    c = 24'h00FFFF;
      4'h6:    c = 24'hFFB852;
      4'h7:    c = 24'hFFB8AE;
      4'h8:    c = 24'h2121FF;
      4'h9:    c = 24'hFFFFFF;
      4'hA:    c = 24'hDEDEFF;
      4'hB:    c = 24'h00FF00;
      4'hC:    c = 24'hFF8000;
      4'hD:    c = 24'h808080;
      4'hE:    c = 24'h4040FF;
      default: c = 24'hFFD7A0;
    endcase
    return c;
  endfunction

  // cy*160 + cx without a multiplier.
  function automatic fb_addr_t cell_addr(logic [7:0] cx, logic [6:0] cy);
    fb_addr_t cy_w;
    cy_w = fb_addr_t'(cy);
    return (cy_w << 7) + (cy_w << 5) + fb_addr_t'(cx);
  endfunction

endpackage

// File: rtl/fb_clear_seq.sv
// Whole-buffer clear sequencer: walks every cell address once, advancing only on granted cycles.
module fb_clear_seq
  import pacman_video_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       grant_i,
  input  logic       clr_start_i,
  input  color_idx_t clr_color_i,
  output logic       clr_busy_o,
  output logic       clr_we_o,
  output fb_addr_t   clr_addr_o,
  output color_idx_t clr_data_o
);

  typedef enum logic {StIdle, StClear} clr_state_e;

  localparam fb_addr_t LastAddr = fb_addr_t'(FB_CELLS - 1);

  clr_state_e state_q, state_d;
  fb_addr_t   cnt_q, cnt_d;
  color_idx_t color_q, color_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      color_q <= color_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    color_d  = color_q;
    clr_we_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (clr_start_i) begin
          state_d = StClear;
          cnt_d   = '0;
          color_d = clr_color_i;
        end
      end
      StClear: begin
        if (grant_i) begin
          clr_we_o = 1'b1;
          if (cnt_q == LastAddr) state_d = StIdle;
          else                   cnt_d   = cnt_q + fb_addr_t'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign clr_busy_o = (state_q == StClear);
  assign clr_addr_o = cnt_q;
  assign clr_data_o = color_q;

endmodule

// File: rtl/frame_buffer_arbiter.sv
// Shares one single-port palette-index frame buffer between scan-out reads (always win),
// whole-buffer clears and game-logic cell writes, one RAM access per cycle.
module frame_buffer_arbiter #(
  parameter int unsigned FB_W   = 160,
  parameter int unsigned FB_H   = 120,
  parameter int unsigned ADDR_W = 15
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [9:0]        x,
  input  logic [8:0]        y,
  output logic [7:0]        r,
  output logic [7:0]        g,
  output logic [7:0]        b,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [7:0]        wr_x,
  input  logic [6:0]        wr_y,
  input  logic [3:0]        wr_color,
  input  logic              clr_start,
  input  logic [3:0]        clr_color,
  output logic              clr_busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [3:0]        ram_wdata,
  input  logic [3:0]        ram_rdata
);
  import pacman_video_pkg::*;

  logic [7:0]  cx;
  logic [6:0]  cy;
  logic        visible;
  logic        scan_req;
  logic        wr_in_range;
  logic        clr_we;
  fb_addr_t    clr_addr;
  color_idx_t  clr_data;

  logic [14:0] prev_cell_q, prev_cell_d;
  logic        rd_pend_q, rd_pend_d;
  logic        vis_q, vis_d;
  rgb_t        rgb_q, rgb_d;

  assign cx      = x[9:2];
  assign cy      = y[8:2];
  assign visible = (x < 10'(FB_W << CELL_SHIFT)) && (y < 9'(FB_H << CELL_SHIFT));

  // Gated by reset so every combinational output sits at its idle value while reset is held.
  assign scan_req    = !reset && visible && ({cx, cy} != prev_cell_q);
  assign wr_ready    = !reset && !clr_busy && !scan_req;
  assign wr_in_range = (wr_x < 8'(FB_W)) && (wr_y < 7'(FB_H));

  fb_clear_seq u_clear (
    .clk_i       (CLOCK_50),
    .rst_i       (reset),
    .grant_i     (!scan_req),
    .clr_start_i (clr_start),
    .clr_color_i (clr_color),
    .clr_busy_o  (clr_busy),
    .clr_we_o    (clr_we),
    .clr_addr_o  (clr_addr),
    .clr_data_o  (clr_data)
  );

  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (scan_req) begin
      ram_addr = ADDR_W'(cell_addr(cx, cy));
    end else if (clr_we) begin
      ram_we    = 1'b1;
      ram_addr  = ADDR_W'(clr_addr);
      ram_wdata = clr_data;
    end else if (wr_valid && wr_ready && wr_in_range) begin
      ram_we    = 1'b1;
      ram_addr  = ADDR_W'(cell_addr(wr_x, wr_y));
      ram_wdata = wr_color;
    end
  end

  // Read issued in N returns in N+1; colour lands in the output register for N+2.
  always_comb begin
    prev_cell_d = {cx, cy};
    rd_pend_d   = scan_req;
    vis_d       = visible;
    rgb_d       = rgb_q;
    if (!vis_q)         rgb_d = '0;
    else if (rd_pend_q) rgb_d = palette_lookup(ram_rdata);
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      prev_cell_q <= '1;
      rd_pend_q   <= 1'b0;
      vis_q       <= 1'b0;
      rgb_q       <= '0;
    end else begin
      prev_cell_q <= prev_cell_d;
      rd_pend_q   <= rd_pend_d;
      vis_q       <= vis_d;
      rgb_q       <= rgb_d;
    end
  end

  assign r = rgb_q.r;
  assign g = rgb_q.g;
  assign b = rgb_q.b;

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Self-checking bench: random scan/write traffic against a cell-level reference model and RAM.
module tb_frame_buffer_arbiter;

  logic        CLOCK_50 = 1'b0;
  logic        reset    = 1'b0;
  logic [9:0]  x        = '0;
  logic [8:0]  y        = '0;
  logic [7:0]  r, g, b;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [7:0]  wr_x     = '0;
  logic [6:0]  wr_y     = '0;
  logic [3:0]  wr_color = '0;
  logic        clr_start = 1'b0;
  logic [3:0]  clr_color = '0;
  logic        clr_busy;
  logic [14:0] ram_addr;
  logic        ram_we;
  logic [3:0]  ram_wdata;
  logic [3:0]  ram_rdata;

  int vectors     = 0;
  int miscompares = 0;

  frame_buffer_arbiter u_dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .x         (x),
    .y         (y),
    .r         (r),
    .g         (g),
    .b         (b),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_x      (wr_x),
    .wr_y      (wr_y),
    .wr_color  (wr_color),
    .clr_start (clr_start),
    .clr_color (clr_color),
    .clr_busy  (clr_busy),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  initial forever #5 CLOCK_50 = ~CLOCK_50;

  // External single-port RAM, 1-cycle read latency, preloaded with a known pattern.
  logic [3:0] ram_mem [32768];
  initial begin
    for (int i = 0; i < 32768; i++) ram_mem[i] = 4'((i * 7 + 5) & 15);
    forever begin
      @(posedge CLOCK_50);
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      ram_rdata <= ram_mem[ram_addr];
    end
  end

  // Reference model state.
  logic [3:0]  exp_mem [19200];
  int          m_pcx, m_pcy, m_cnt, m_ccol, cyc;
  bit          m_clr, m_hs, s1_vis, s1_scan, wr_rand, scan_rand;
  logic [23:0] m_rgb, s1_rgb;

  function automatic logic [23:0] pal(input int idx);
    logic [23:0] tbl [16];
    tbl = '{24'h000000, 24'h2121DE, 24'hFFFF00, 24'hFF0000, 24'hFFB8FF, 24'h00FFFF,
            24'hFFB852, 24'hFFB8AE, 24'h2121FF, 24'hFFFFFF, 24'hDEDEFF, 24'h00FF00,
            24'hFF8000, 24'h808080, 24'h4040FF, 24'hFFD7A0};
    return tbl[idx[3:0]];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic model_reset();
    m_pcx = 255; m_pcy = 127; m_clr = 0; m_cnt = 0; m_hs = 0;
    s1_vis = 0; s1_scan = 0; s1_rgb = '0; m_rgb = '0;
  endtask

  // Called just after a rising edge; holds reset over one edge.
  task automatic do_reset();
    reset = 1'b1; wr_valid = 1'b0; clr_start = 1'b0;
    #1;
    chk("rst_clr_busy", 32'(clr_busy), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_ram_wdata", 32'(ram_wdata), 0);
    chk("rst_wr_ready", 32'(wr_ready), 0);
    chk("rst_rgb", 32'({r, g, b}), 0);
    @(posedge CLOCK_50);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  // One clock of checking: predict this cycle's outputs, compare mid-cycle, advance the model.
  task automatic cycle();
    int cx, cy, e_addr;
    bit vis, scan, e_ready, e_we, inr;
    logic [3:0] e_data;
    @(negedge CLOCK_50);
    cx      = int'(x) >> 2;
    cy      = int'(y) >> 2;
    vis     = (int'(x) < 640) && (int'(y) < 480);
    scan    = vis && (cx != m_pcx || cy != m_pcy);
    e_ready = !m_clr && !scan;
    m_hs    = wr_valid && e_ready;
    inr     = (int'(wr_x) < 160) && (int'(wr_y) < 120);
    e_we = 0; e_addr = 0; e_data = '0;
    if (scan) e_addr = cy * 160 + cx;
    else if (m_clr) begin
      e_we = 1; e_addr = m_cnt; e_data = 4'(m_ccol);
    end else if (m_hs && inr) begin
      e_we = 1; e_addr = int'(wr_y) * 160 + int'(wr_x); e_data = wr_color;
    end
    chk("wr_ready", 32'(wr_ready), 32'(e_ready));
    chk("clr_busy", 32'(clr_busy), 32'(m_clr));
    chk("ram_we", 32'(ram_we), 32'(e_we));
    if (scan || e_we) chk("ram_addr", 32'(ram_addr), 32'(e_addr));
    if (e_we) chk("ram_wdata", 32'(ram_wdata), 32'(e_data));
    chk("rgb", 32'({r, g, b}), 32'(m_rgb));
    @(posedge CLOCK_50);
    if (e_we) exp_mem[e_addr] = e_data;
    if (!s1_vis) m_rgb = '0;
    else if (s1_scan) m_rgb = s1_rgb;
    s1_vis  = vis;
    s1_scan = scan;
    s1_rgb  = scan ? pal(int'(exp_mem[e_addr])) : '0;
    m_pcx = cx;
    m_pcy = cy;
    if (m_clr && !scan) begin
      if (m_cnt == 19199) m_clr = 0;
      else m_cnt++;
    end else if (!m_clr && clr_start) begin
      m_clr = 1; m_cnt = 0; m_ccol = int'(clr_color);
    end
    cyc++;
    #1;
  endtask

  task automatic stim();
    if (m_hs) wr_valid = 1'b0;
    if (wr_rand && !wr_valid && $urandom_range(0, 2) == 0) begin
      wr_valid = 1'b1;
      wr_x     = 8'($urandom_range(0, 169));
      wr_y     = 7'($urandom_range(0, 124));
      wr_color = 4'($urandom_range(0, 15));
    end
    if (scan_rand) begin
      if (cyc % 8 == 0) begin
        x = 10'($urandom_range(0, 799));
        y = 9'($urandom_range(0, 524));
      end else if (cyc % 2 == 0) begin
        x[1:0] = x[1:0] + 2'd1;
      end
    end
  endtask

  task automatic tick();
    cycle();
    stim();
  endtask

  initial begin
    for (int i = 0; i < 19200; i++) exp_mem[i] = 4'((i * 7 + 5) & 15);
    wr_rand = 0; scan_rand = 0; cyc = 0; m_ccol = 0;
    model_reset();
    #1;
    do_reset();

    // First read at cell 0 after reset; its colour two cycles later.
    tick(); tick();
    chk("first_pixel", 32'({r, g, b}), 32'(pal(5)));
    tick(); tick();

    // Write in a quiet cycle: cell (3,2) -> address 323.
    wr_x = 8'd3; wr_y = 7'd2; wr_color = 4'd9; wr_valid = 1'b1;
    tick(); tick();

    // Write pending across a cell change, then read it back through scan-out.
    x = 10'd8; wr_x = 8'd10; wr_y = 7'd10; wr_color = 4'd7; wr_valid = 1'b1;
    repeat (8) tick();
    x = 10'd40; y = 9'd40;
    tick(); tick(); tick();
    chk("readback_7", 32'({r, g, b}), 32'(pal(7)));

    // Blanking region: no read, black output, out-of-range write handshakes silently.
    x = 10'd700; y = 9'd100; wr_x = 8'd160; wr_y = 7'd5; wr_color = 4'd3; wr_valid = 1'b1;
    tick(); tick(); tick();
    chk("blank_rgb", 32'({r, g, b}), 0);

    wr_rand = 1; scan_rand = 1;
    repeat (2000) tick();

    // Black clear interrupted by reset at count 5000.
    clr_color = 4'd0; clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    for (int i = 0; i < 8000 && m_cnt < 5000; i++) tick();
    do_reset();

    // Full clear to a new colour, restarting at address 0.
    clr_color = 4'hA; clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    for (int i = 0; i < 30000 && m_clr; i++) tick();
    repeat (1500) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
